// File: rtl/audio_dac_streamer.sv
// Streams Avalon-ST stereo sample pairs through a small FIFO to an I2S codec
// DAC input. The codec is clock master: bclk and daclrc arrive asynchronously
// and are synchronized into the clk domain before any edge is acted upon.
module audio_dac_streamer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [2*DATA_WIDTH-1:0]     snk_data,
    input  logic                        snk_valid,
    output logic                        snk_ready,
    input  logic                        aud_bclk,
    input  logic                        aud_daclrc,
    output logic                        aud_dacdat,
    input  logic                        clear_underflow,
    output logic                        underflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned PAIR_W = 2 * DATA_WIDTH;
    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = ADDR_W + 1;
    localparam int unsigned CNT_W  = $clog2(DATA_WIDTH + 1);

    // [0],[1] = synchronizer stages, [2] = history for edge detection
    logic [2:0] bclk_sync;
    logic [2:0] lrc_sync;

    logic [PAIR_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic [DATA_WIDTH-1:0] right_hold;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;

    logic                  bclk_fall_c;
    logic                  lrc_fall_c;
    logic                  lrc_rise_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  fifo_empty_c;
    logic [PAIR_W-1:0]     rd_data_c;
    logic [LVL_W-1:0]      level_nxt_c;
    logic [DATA_WIDTH-1:0] right_nxt_c;
    logic [DATA_WIDTH-1:0] shreg_nxt_c;
    logic [CNT_W-1:0]      cnt_nxt_c;
    logic                  dat_nxt_c;
    logic                  uf_nxt_c;

    // Synchronize codec clocks and keep one history flop each
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lrc_sync  <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], aud_bclk};
            lrc_sync  <= {lrc_sync[1:0], aud_daclrc};
        end
    end

    // Edge strobes and FIFO handshake; a pop only sees occupancy before this cycle's push
    always_comb begin
        bclk_fall_c  = bclk_sync[2] & ~bclk_sync[1];
        lrc_fall_c   = lrc_sync[2] & ~lrc_sync[1];
        lrc_rise_c   = ~lrc_sync[2] & lrc_sync[1];
        fifo_empty_c = (fifo_level == '0);
        push_c       = snk_valid & snk_ready;
        pop_c        = lrc_fall_c & ~fifo_empty_c;
        rd_data_c    = fifo_mem[rd_ptr];
        level_nxt_c  = fifo_level;
        case ({push_c, pop_c})
            2'b10:   level_nxt_c = fifo_level + LVL_W'(1);
            2'b01:   level_nxt_c = fifo_level - LVL_W'(1);
            default: level_nxt_c = fifo_level;
        endcase
    end

    // FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr] <= snk_data;
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            snk_ready  <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            fifo_level <= level_nxt_c;
            snk_ready  <= (level_nxt_c != LVL_W'(FIFO_DEPTH));
        end
    end

    // Serializer next state: LR edges win over bit clock, MSB goes out one bclk after LR
    always_comb begin
        right_nxt_c = right_hold;
        shreg_nxt_c = shreg;
        cnt_nxt_c   = bit_cnt;
        dat_nxt_c   = aud_dacdat;
        uf_nxt_c    = underflow;
        if (lrc_fall_c) begin
            if (pop_c) begin
                shreg_nxt_c = rd_data_c[PAIR_W-1:DATA_WIDTH];
                right_nxt_c = rd_data_c[DATA_WIDTH-1:0];
            end else begin
                shreg_nxt_c = '0;
                right_nxt_c = '0;
            end
            cnt_nxt_c = CNT_W'(DATA_WIDTH);
        end else if (lrc_rise_c) begin
            shreg_nxt_c = right_hold;
            cnt_nxt_c   = CNT_W'(DATA_WIDTH);
        end else if (bclk_fall_c) begin
            if (bit_cnt != '0) begin
                dat_nxt_c   = shreg[DATA_WIDTH-1];
                shreg_nxt_c = {shreg[DATA_WIDTH-2:0], 1'b0};
                cnt_nxt_c   = bit_cnt - CNT_W'(1);
            end else begin
                dat_nxt_c = 1'b0;
            end
        end
        if (lrc_fall_c && fifo_empty_c) begin
            uf_nxt_c = 1'b1;
        end else if (clear_underflow) begin
            uf_nxt_c = 1'b0;
        end
    end

    // Serializer and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            right_hold <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            aud_dacdat <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            right_hold <= right_nxt_c;
            shreg      <= shreg_nxt_c;
            bit_cnt    <= cnt_nxt_c;
            aud_dacdat <= dat_nxt_c;
            underflow  <= uf_nxt_c;
        end
    end

endmodule

// File: tb/tb_audio_dac_streamer.sv
// Bench for audio_dac_streamer: drives a codec-master I2S clock model and
// compares the serial stream against pairs recorded in a scoreboard queue.
module tb_audio_dac_streamer;

    logic        clk;
    logic        reset_n;
    logic [31:0] snk_data;
    logic        snk_valid;
    logic        snk_ready;
    logic        aud_bclk;
    logic        aud_daclrc;
    logic        aud_dacdat;
    logic        clear_underflow;
    logic        underflow;
    logic [3:0]  fifo_level;

    int n_total = 0;
    int n_pass  = 0;

    logic        cap[$];
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] pair;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t vecs[5];

    audio_dac_streamer #(.DATA_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .snk_data        (snk_data),
        .snk_valid       (snk_valid),
        .snk_ready       (snk_ready),
        .aud_bclk        (aud_bclk),
        .aud_daclrc      (aud_daclrc),
        .aud_dacdat      (aud_dacdat),
        .clear_underflow (clear_underflow),
        .underflow       (underflow),
        .fifo_level      (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reset with codec pins idle high (right channel, bclk high)
    task automatic do_reset();
        reset_n         = 1'b0;
        snk_valid       = 1'b0;
        snk_data        = '0;
        clear_underflow = 1'b0;
        aud_bclk        = 1'b1;
        aud_daclrc      = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    // One-cycle push attempt; accepted pairs go to the scoreboard
    task automatic push_pair(input logic [31:0] d, input logic [31:0] e, output bit acc);
        @(posedge clk); #2;
        snk_data  = d;
        snk_valid = 1'b1;
        acc       = snk_ready;
        if (acc) exp_q.push_back(e);
        @(posedge clk); #2;
        snk_valid = 1'b0;
    endtask

    // One codec channel of n bclk periods (bclk = clk/8). LR changes with the
    // first bclk fall (lag=0) or one clk later (lag=1). dacdat is sampled on
    // every bclk rise; s returns the capture index of the channel's first rise.
    task automatic codec_chan(input logic v, input int n, input int lag, output int s);
        s = cap.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            aud_bclk = 1'b0;
            if (i == 0 && lag == 0) aud_daclrc = v;
            @(posedge clk); #2;
            if (i == 0 && lag != 0) aud_daclrc = v;
            repeat (3) @(posedge clk);
            #2;
            aud_bclk = 1'b1;
            cap.push_back(aud_dacdat);
            repeat (3) @(posedge clk);
        end
    endtask

    // n bits of a channel, MSB first, starting at the bclk after its LR edge
    function automatic logic [15:0] get_bits(input int s, input int n);
        logic [15:0] w;
        w = '0;
        for (int k = 1; k <= n; k++) begin
            if (s + k < cap.size()) w = {w[14:0], cap[s + k]};
            else w = {w[14:0], 1'bx};
        end
        return w;
    endfunction

    function automatic logic [31:0] pop_exp();
        logic [31:0] e;
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        return e;
    endfunction

    initial begin
        int          sl[5];
        int          sr[5];
        int          s0, s1, s2, s3, s4;
        int          n_acc;
        bit          acc;
        logic [31:0] e;

        vecs[0] = '{32'hA5A5_3C3C, 16'hA5A5, 16'h3C3C};
        vecs[1] = '{32'hFFFF_0000, 16'hFFFF, 16'h0000};
        vecs[2] = '{32'h0001_8000, 16'h0001, 16'h8000};
        vecs[3] = '{32'h1234_ABCD, 16'h1234, 16'hABCD};
        vecs[4] = '{32'h8001_7FFE, 16'h8001, 16'h7FFE};

        // Reset values
        reset_n = 1'b0; snk_valid = 1'b0; snk_data = '0; clear_underflow = 1'b0;
        aud_bclk = 1'b1; aud_daclrc = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dacdat", 32'(aud_dacdat), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ready", 32'(snk_ready), 32'd1);

        // Table: push all pairs, stream them, compare each channel
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push_pair(vecs[k].pair, {vecs[k].exp_l, vecs[k].exp_r}, acc);
            chk("tbl_accept", 32'(acc), 32'd1);
        end
        chk("tbl_level", 32'(fifo_level), 32'd5);
        for (int k = 0; k < 5; k++) begin
            codec_chan(1'b0, 16, 1, sl[k]);
            codec_chan(1'b1, 16, 1, sr[k]);
        end
        chk("tbl_no_underflow", 32'(underflow), 32'd0);
        codec_chan(1'b0, 16, 1, s0);
        codec_chan(1'b1, 16, 1, s1);
        codec_chan(1'b0, 2, 1, s2);
        for (int k = 0; k < 5; k++) begin
            e = pop_exp();
            chk($sformatf("tbl_left%0d", k), 32'(get_bits(sl[k], 16)), 32'(e[31:16]));
            chk($sformatf("tbl_right%0d", k), 32'(get_bits(sr[k], 16)), 32'(e[15:0]));
        end

        // Underflow frame outputs zeros and sets the sticky flag
        chk("uf_left_zero", 32'(get_bits(s0, 16)), 32'd0);
        chk("uf_right_zero", 32'(get_bits(s1, 16)), 32'd0);
        chk("uf_set", 32'(underflow), 32'd1);
        @(posedge clk); #2 clear_underflow = 1'b1;
        @(posedge clk); #2 clear_underflow = 1'b0;
        chk("uf_cleared", 32'(underflow), 32'd0);

        // Clear pulse in the same cycle as an underflow set: flag stays set
        aud_daclrc = 1'b1;
        repeat (6) @(posedge clk);
        @(posedge clk); #2 aud_daclrc = 1'b0;
        repeat (2) @(posedge clk);
        #2 clear_underflow = 1'b1;
        @(posedge clk); #2 clear_underflow = 1'b0;
        chk("uf_set_wins", 32'(underflow), 32'd1);

        // Push coincident with left start on empty FIFO
        aud_daclrc = 1'b1;
        repeat (6) @(posedge clk);
        @(posedge clk); #2 clear_underflow = 1'b1;
        @(posedge clk); #2 clear_underflow = 1'b0;
        chk("co_uf_clear", 32'(underflow), 32'd0);
        @(posedge clk); #2 aud_daclrc = 1'b0;
        repeat (2) @(posedge clk);
        #2 snk_data = 32'hC3C3_5A5A; snk_valid = 1'b1;
        exp_q.push_back(32'hC3C3_5A5A);
        @(posedge clk); #2 snk_valid = 1'b0;
        chk("co_underflow", 32'(underflow), 32'd1);
        chk("co_level", 32'(fifo_level), 32'd1);
        codec_chan(1'b1, 16, 1, s0);
        codec_chan(1'b0, 16, 1, s1);
        codec_chan(1'b1, 16, 1, s2);
        codec_chan(1'b0, 2, 1, s3);
        e = pop_exp();
        chk("co_right_zero", 32'(get_bits(s0, 16)), 32'd0);
        chk("co_left_next", 32'(get_bits(s1, 16)), 32'(e[31:16]));
        chk("co_right_next", 32'(get_bits(s2, 16)), 32'(e[15:0]));

        // Fill: 9 attempts, 8 accepted, then one left start frees a slot
        do_reset();
        n_acc = 0;
        for (int k = 0; k < 9; k++) begin
            push_pair(32'h1000_0000 + 32'(k), 32'h1000_0000 + 32'(k), acc);
            if (acc) n_acc++;
        end
        chk("full_accepted", 32'(n_acc), 32'd8);
        chk("full_level", 32'(fifo_level), 32'd8);
        chk("full_ready", 32'(snk_ready), 32'd0);
        codec_chan(1'b0, 4, 0, s0);
        repeat (2) @(posedge clk);
        chk("full_pop_level", 32'(fifo_level), 32'd7);
        chk("full_pop_ready", 32'(snk_ready), 32'd1);

        // Reset mid-frame discards FIFO and in-flight sample
        do_reset();
        push_pair(32'hFFFF_0F0F, 32'hFFFF_0F0F, acc);
        for (int k = 0; k < 3; k++) push_pair(32'h2222_0000 + 32'(k), 32'h0, acc);
        codec_chan(1'b0, 6, 1, s0);
        chk("mid_bits", 32'(get_bits(s0, 5)), 32'h1F);
        chk("mid_pre_level", 32'(fifo_level), 32'd3);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_dacdat", 32'(aud_dacdat), 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_underflow", 32'(underflow), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        push_pair(32'h6D6D_9292, 32'h6D6D_9292, acc);
        codec_chan(1'b0, 10, 1, s0);
        codec_chan(1'b1, 16, 1, s1);
        chk("post_rise_no_pop", 32'(fifo_level), 32'd1);
        codec_chan(1'b0, 16, 1, s2);
        codec_chan(1'b1, 16, 1, s3);
        codec_chan(1'b0, 2, 1, s4);
        e = pop_exp();
        chk("post_rst_silent", 32'(get_bits(s0, 9)), 32'd0);
        chk("post_rise_zero", 32'(get_bits(s1, 16)), 32'd0);
        chk("post_left", 32'(get_bits(s2, 16)), 32'(e[31:16]));
        chk("post_right", 32'(get_bits(s3, 16)), 32'(e[15:0]));

        // Short left channel (10 bclk): aborted after 9 bits, no extra pop
        do_reset();
        push_pair(32'hA5A5_3C3C, 32'hA5A5_3C3C, acc);
        push_pair(32'h1234_5678, 32'h1234_5678, acc);
        codec_chan(1'b0, 10, 1, s0);
        codec_chan(1'b1, 16, 0, s1);
        chk("short_level", 32'(fifo_level), 32'd1);
        codec_chan(1'b0, 16, 1, s2);
        codec_chan(1'b1, 16, 1, s3);
        codec_chan(1'b0, 2, 1, s4);
        e = pop_exp();
        chk("short_left9", 32'(get_bits(s0, 9)), 32'(e[31:16] >> 7));
        chk("short_right", 32'(get_bits(s1, 16)), 32'(e[15:0]));
        e = pop_exp();
        chk("short_next_left", 32'(get_bits(s2, 16)), 32'(e[31:16]));
        chk("short_next_right", 32'(get_bits(s3, 16)), 32'(e[15:0]));
        chk("short_final_level", 32'(fifo_level), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/audio_dac_streamer.md
AUDIO_DAC_STREAMER -- requirements
Module: audio_dac_streamer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 16, bits per channel; FIFO_DEPTH, default 8, sample-pair FIFO entries (power of two).
REQ-002 clk  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 snk_data  input  2*DATA_WIDTH  Avalon-ST sample pair, [2W-1:W]=left, [W-1:0]=right.
REQ-005 snk_valid  input  1  sample pair valid.
REQ-006 snk_ready  output  1  FIFO can accept a pair.
REQ-007 aud_bclk  input  1  codec bit clock (codec is master), asynchronous to clk.
REQ-008 aud_daclrc  input  1  codec DAC LR clock, 0=left, 1=right, asynchronous to clk.
REQ-009 aud_dacdat  output  1  serial DAC data to codec.
REQ-010 clear_underflow  input  1  one-cycle pulse clears underflow flag.
REQ-011 underflow  output  1  sticky underflow flag.
REQ-012 fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 aud_bclk and aud_daclrc SHALL each pass a 2-flop synchronizer plus one history flop; edges SHALL be detected from synchronized/history pair (3 clk pin-to-detect latency).
REQ-014 snk_ready SHALL equal (fifo_level != FIFO_DEPTH); a pair SHALL be written when snk_valid && snk_ready.
REQ-015 Detected daclrc falling edge (left start): if FIFO non-empty at that cycle, pop one pair into left/right holding registers; else load zeros into both and set underflow.
REQ-016 Push into empty FIFO in the same cycle as a left-start pop SHALL NOT satisfy that pop (underflow, zeros); the pushed pair SHALL be retained for the next frame.
REQ-017 Simultaneous push and pop with FIFO non-empty and not full SHALL leave fifo_level unchanged.
REQ-018 Detected daclrc rising edge (right start) SHALL load the right holding register into the shift register; no FIFO pop.
REQ-019 Format SHALL be I2S: on any daclrc edge, bit counter loads DATA_WIDTH and aud_dacdat holds; each subsequent detected bclk falling edge SHALL drive the next bit, MSB first.
REQ-020 If a bclk falling edge and a daclrc edge are detected in the same cycle, daclrc handling SHALL take precedence and no bit SHALL be shifted that cycle.
REQ-021 After DATA_WIDTH bits of a channel, aud_dacdat SHALL drive 0 until the next daclrc edge.
REQ-022 A daclrc edge arriving before DATA_WIDTH bits are sent SHALL abort the current channel and start the new one.
REQ-023 underflow SHALL remain 1 until clear_underflow; a set and clear in the same cycle SHALL leave it 1.
REQ-024 Left-channel shift register load SHALL occur in the same cycle as the pop (REQ-015), from the popped left half.

Reset
REQ-025 While reset_n=0: aud_dacdat=0, underflow=0, fifo_level=0, snk_ready=1, synchronizer/history flops=0, bit counter=0, holding/shift registers=0.
REQ-026 After reset release, no output bits SHALL be sent until the first detected daclrc falling edge; a rising edge seen first SHALL output zeros without popping.
REQ-027 Reset asserted mid-frame SHALL discard FIFO contents and the in-flight sample immediately.

Verification
REQ-028 Push 0xA5A5_3C3C, then run codec frames (bclk=clk/8, 16 bclk per channel) -> dacdat left bits 1010010110100101 starting 2nd bclk fall after lrc fall, right 0011110000111100, underflow=0.
REQ-029 Push 9 pairs with no codec clocks -> 8 accepted, snk_ready=0 after 8th, fifo_level=8; one left-start -> level 7, snk_ready=1.
REQ-030 Empty FIFO, one left-start -> dacdat all 0 for frame, underflow=1; clear_underflow pulse -> underflow=0; simultaneous set/clear -> underflow=1.
REQ-031 Push coincident with left-start on empty FIFO -> underflow=1, fifo_level=1 afterward, pair output next frame.
REQ-032 Assert reset_n low after 5 left bits with level=3 -> dacdat=0, level=0, underflow=0; after release, output starts only at next lrc falling edge.
REQ-033 Shorten channel to 10 bclk (lrc edge early) -> channel aborted after 9 bits, next channel MSB on schedule, no extra pop.
